// File: rtl/prf_mp.sv
// Physical register file: NUM_RD registered read ports with same-cycle CDB bypass, NUM_WR write ports, per-preg ready scoreboard.
// 1-cycle read latency; no backpressure, every port accepts every cycle.
module prf_mp #(
    parameter int PRF_DEPTH = 96,
    parameter int DATA_W    = 32,
    parameter int NUM_RD    = 12,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 1,
    localparam int PADDR_W  = $clog2(PRF_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR*PADDR_W-1:0]     wr_paddr,
    input  logic [NUM_WR*DATA_W-1:0]      wr_data,
    input  logic [NUM_ALLOC-1:0]          alloc_en,
    input  logic [NUM_ALLOC*PADDR_W-1:0]  alloc_paddr,
    input  logic [NUM_RD-1:0]             rd_en,
    input  logic [NUM_RD*PADDR_W-1:0]     rd_paddr,
    output logic [NUM_RD*DATA_W-1:0]      rd_data,
    output logic [NUM_RD-1:0]             rd_ready
);

    logic [DATA_W-1:0]    mem [PRF_DEPTH];
    logic [PRF_DEPTH-1:0] ready;

    logic [PADDR_W-1:0]   wa [NUM_WR];
    logic [DATA_W-1:0]    wd [NUM_WR];
    logic [NUM_WR-1:0]    wr_ok;
    logic [PADDR_W-1:0]   aa [NUM_ALLOC];
    logic [NUM_ALLOC-1:0] alloc_ok;
    logic [PADDR_W-1:0]   ra [NUM_RD];

    logic [NUM_RD*DATA_W-1:0] rd_data_nxt;
    logic [NUM_RD-1:0]        rd_ready_nxt;

    function automatic logic in_range(input logic [PADDR_W-1:0] a);
        return int'(a) < PRF_DEPTH;
    endfunction

    // Qualified write/alloc strobes: p0 and out-of-range addresses are dropped here.
    always_comb begin
        for (int i = 0; i < NUM_WR; i++) begin
            wa[i]    = wr_paddr[i*PADDR_W +: PADDR_W];
            wd[i]    = wr_data[i*DATA_W +: DATA_W];
            wr_ok[i] = wr_en[i] && (wa[i] != '0) && in_range(wa[i]);
        end
        for (int j = 0; j < NUM_ALLOC; j++) begin
            aa[j]       = alloc_paddr[j*PADDR_W +: PADDR_W];
            alloc_ok[j] = alloc_en[j] && (aa[j] != '0) && in_range(aa[j]);
        end
    end

    // Read side sees pre-update array state; a matching CDB write overrides it (highest port last).
    always_comb begin
        rd_data_nxt  = '0;
        rd_ready_nxt = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra[k] = rd_paddr[k*PADDR_W +: PADDR_W];
            if (in_range(ra[k])) begin
                if (ra[k] == '0) begin
                    rd_ready_nxt[k] = 1'b1;
                end else begin
                    rd_data_nxt[k*DATA_W +: DATA_W] = mem[ra[k]];
                    rd_ready_nxt[k]                 = ready[ra[k]];
                    for (int i = 0; i < NUM_WR; i++) begin
                        if (wr_ok[i] && (wa[i] == ra[k])) begin
                            rd_data_nxt[k*DATA_W +: DATA_W] = wd[i];
                            rd_ready_nxt[k]                 = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < PRF_DEPTH; e++) begin
                mem[e] <= '0;
            end
            ready    <= '1;
            rd_data  <= '0;
            rd_ready <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_ok[i]) begin
                    mem[wa[i]]   <= wd[i];
                    ready[wa[i]] <= 1'b1;
                end
            end
            // Allocation is applied after writeback so a same-cycle alloc leaves the preg not-ready.
            for (int j = 0; j < NUM_ALLOC; j++) begin
                if (alloc_ok[j]) begin
                    ready[aa[j]] <= 1'b0;
                end
            end
            for (int k = 0; k < NUM_RD; k++) begin
                if (rd_en[k]) begin
                    rd_data[k*DATA_W +: DATA_W] <= rd_data_nxt[k*DATA_W +: DATA_W];
                    rd_ready[k]                 <= rd_ready_nxt[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_WR; i++) begin
                assert (!(wr_en[i] && !in_range(wa[i])))
                    else $error("prf_mp: write to out-of-range preg");
                for (int i2 = i + 1; i2 < NUM_WR; i2++) begin
                    assert (!(wr_ok[i] && wr_ok[i2] && (wa[i] == wa[i2])))
                        else $info("prf_mp: multiple CDB ports wrote the same preg");
                end
            end
            for (int j = 0; j < NUM_ALLOC; j++) begin
                assert (!(alloc_en[j] && !in_range(aa[j])))
                    else $error("prf_mp: alloc of out-of-range preg");
            end
            for (int k = 0; k < NUM_RD; k++) begin
                assert (!(rd_en[k] && !in_range(ra[k])))
                    else $error("prf_mp: read of out-of-range preg");
            end
        end
    end

endmodule
